// File: rtl/flick_pkg.sv
// Shared types and constants for the flick button conditioner.
package flick_pkg;

  localparam int unsigned GLITCH_W = 8;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } flick_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/flick_conditioner.sv
// Debounces the flick button into a clean level plus rise/fall pulses.
// Define FLICK_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module flick_conditioner
  import flick_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flick_raw,
  output logic                flick,
  output logic                flick_rise,
`ifdef FLICK_GLITCH_CNT_EN
  output logic [GLITCH_W-1:0] glitch_cnt,
`endif
  output logic                flick_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s2;
  flick_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flick_nxt, rise_nxt, fall_nxt;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (flick_raw),
    .q       (s2)
  );

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= LOW;
      cnt        <= '0;
      flick      <= 1'b0;
      flick_rise <= 1'b0;
      flick_fall <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      flick      <= flick_nxt;
      flick_rise <= rise_nxt;
      flick_fall <= fall_nxt;
    end
  end

  // Next state: a check state needs an unbroken run of the opposite level
  always_comb begin
    state_nxt = LOW;
    cnt_nxt   = '0;
    case (state)
      LOW: begin
        if (s2) begin
          state_nxt = RISE_CHK;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = LOW;
        end
      end
      RISE_CHK: begin
        if (!s2) begin
          state_nxt = LOW;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = HIGH;
        end else begin
          state_nxt = RISE_CHK;
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = FALL_CHK;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = HIGH;
        end
      end
      FALL_CHK: begin
        if (s2) begin
          state_nxt = HIGH;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = LOW;
        end else begin
          state_nxt = FALL_CHK;
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
      end
    endcase
  end

  // Output values for the next cycle, taken from the transition
  always_comb begin
    flick_nxt = 1'b0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    flick_nxt = (state_nxt == HIGH) || (state_nxt == FALL_CHK);
    rise_nxt  = (state == RISE_CHK) && (state_nxt == HIGH);
    fall_nxt  = (state == FALL_CHK) && (state_nxt == LOW);
  end

`ifdef FLICK_GLITCH_CNT_EN
  logic abort_c;

  assign abort_c = ((state == RISE_CHK) && (state_nxt == LOW)) ||
                   ((state == FALL_CHK) && (state_nxt == HIGH));

  // Saturating count of aborted transitions
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      glitch_cnt <= '0;
    end else if (abort_c && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule
